// File: rtl/sha1_msg_fetcher.sv
// -----------------------------------------------------------------------------
// sha1_msg_fetcher
//
// Read-side front end for the SHA-1 co-processor. On start it walks the
// message in the DPSRAM one 32-bit word at a time over port A. Each
// little-endian memory word is turned into a big-endian SHA-1 word, and the
// module appends the 0x80 pad byte, the zero fill and the 64-bit bit-length
// field. The result is streamed as 512-bit blocks (16 words each) to the
// compression core over a valid/ready handshake. The memory is never written.
//
// Ports
//   clk, nreset         clock; synchronous active-low reset
//   start               begin a message (honoured only when idle)
//   message_addr        byte address of the message (bits [1:0] ignored)
//   message_size        message length in bytes
//   port_A_*            DPSRAM port A (read-only use; data one cycle after addr)
//   w_data / w_valid    padded big-endian word stream, accepted on w_ready
//   w_first / w_last    word 0 of a block / final word of the final block
//   busy                a message is in progress
//   done                one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module sha1_msg_fetcher (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] message_size,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out,
  output logic [31:0] w_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        w_first,
  output logic        w_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_t;

  // Word indices and counts are 33 bits wide so that the stream length for a
  // 2^32-1 byte message cannot wrap.
  state_t      state_q, state_d;
  logic [32:0] k_q, k_d;              // index of the word currently offered
  logic [31:0] len_q, len_d;          // message length in bytes
  logic [15:0] base_q, base_d;        // word-aligned base address
  logic [32:0] t_last_q, t_last_d;    // index of the final stream word
  logic [32:0] r_words_q, r_words_d;  // number of memory words to read
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // Stream geometry derived from the incoming size, used when start is taken.
  logic [32:0] len_in;
  logic [32:0] t_last_in;
  logic [32:0] r_words_in;
  logic [32:0] k_next;

  assign len_in     = {1'b0, message_size};
  assign t_last_in  = ((((len_in + 33'd8) >> 6) + 33'd1) << 4) - 33'd1;
  assign r_words_in = (len_in + 33'd3) >> 2;
  assign k_next     = k_q + 33'd1;

  // Words that do not come from memory: the lone 0x80 pad word (only when the
  // length is a multiple of 4), zero fill, and the two length words.
  function automatic logic [31:0] gen_word(input logic [32:0] k,
                                           input logic [31:0] len,
                                           input logic [32:0] t_last);
    if (k == t_last)
      gen_word = {len[28:0], 3'b000};
    else if (k == t_last - 33'd1)
      gen_word = {29'd0, len[31:29]};
    else if (k == {3'b000, len[31:2]})
      gen_word = 32'h8000_0000;
    else
      gen_word = 32'h0000_0000;
  endfunction

  // Byte-swap the memory word; the last, partial word keeps only the valid
  // message bytes and gets the 0x80 pad byte right after them.
  logic [31:0] swapped;
  logic [31:0] capt_word;

  assign swapped = {port_A_data_out[7:0],   port_A_data_out[15:8],
                    port_A_data_out[23:16], port_A_data_out[31:24]};

  always_comb begin
    capt_word = swapped;
    if (k_q == {3'b000, len_q[31:2]}) begin
      case (len_q[1:0])
        2'd1:    capt_word = (swapped & 32'hFF00_0000) | 32'h0080_0000;
        2'd2:    capt_word = (swapped & 32'hFFFF_0000) | 32'h0000_8000;
        2'd3:    capt_word = (swapped & 32'hFFFF_FF00) | 32'h0000_0080;
        default: capt_word = swapped;
      endcase
    end
  end

  // Next-state and datapath update.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    base_d    = base_q;
    t_last_d  = t_last_q;
    r_words_d = r_words_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = message_size;
          base_d    = {message_addr[15:2], 2'b00};
          t_last_d  = t_last_in;
          r_words_d = r_words_in;
          k_d       = 33'd0;
          if (r_words_in != 33'd0) begin
            addr_d  = {message_addr[15:2], 2'b00};
            state_d = S_READ;
          end else begin
            wdata_d = gen_word(33'd0, message_size, t_last_in);
            state_d = S_OUT;
          end
        end
      end

      S_READ: state_d = S_CAPT;

      S_CAPT: begin
        wdata_d = capt_word;
        state_d = S_OUT;
      end

      S_OUT: begin
        // Without a handshake everything holds, including the address.
        if (w_ready) begin
          if (k_q == t_last_q) begin
            state_d = S_DONE;
          end else begin
            k_d = k_next;
            if (k_next < r_words_q) begin
              addr_d  = base_q + {k_next[13:0], 2'b00};
              state_d = S_READ;
            end else begin
              wdata_d = gen_word(k_next, len_q, t_last_q);
            end
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      k_q       <= 33'd0;
      len_q     <= 32'd0;
      base_q    <= 16'd0;
      t_last_q  <= 33'd0;
      r_words_q <= 33'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      base_q    <= base_d;
      t_last_q  <= t_last_d;
      r_words_q <= r_words_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign port_A_clk     = clk;
  assign port_A_addr    = addr_q;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = 32'd0;

  // Flags are qualified with w_valid so they read 0 whenever no word is offered.
  assign w_data  = wdata_q;
  assign w_valid = (state_q == S_OUT);
  assign w_first = w_valid && (k_q[3:0] == 4'd0);
  assign w_last  = w_valid && (k_q == t_last_q);
  assign busy    = (state_q == S_READ) || (state_q == S_CAPT) || (state_q == S_OUT);
  assign done    = (state_q == S_DONE);

  // Address bits outside the 64 KiB window and the byte offset are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{message_addr[31:16], message_addr[1:0]};

endmodule
